aes256_key_schedule: RTL and testbench
======================================

# aes256_key_schedule

Sequential AES-256 key schedule controller that sits directly upstream of the round datapath. It accepts a 256-bit cipher key and iterates the combinational `keyExpansion` block once per clock, with rc = 0..6. It stores all 15 round keys (128 bits each) in an internal register file and serves them to the cipher rounds through an indexed, registered read port.

## Interface
- No parameters; AES-256 only (Nk=8, Nr=14, 15 round keys).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_in` input 256: cipher key; bits [255:224] are word w0.
- `key_load` input 1: load request; sampled only while `load_ready`=1.
- `load_ready` output 1: high in IDLE and DONE; low in EXPAND.
- `sched_valid` output 1: high in DONE only; all 15 round keys are valid.
- `rk_idx` input 4: round key index, 0..14.
- `rk_out` output 128: registered round key `rk[rk_idx]`.

## Operation
- States: IDLE (reset state), EXPAND, DONE.
- Registers:
  - `cur_key` (256 bits)
  - `rc` (4 bits)
  - `rk[0..14]` (15 × 128 bits)
  - `rk_out` (128 bits)
- IDLE/DONE with `key_load`=1 (accepted load):
  - `rk[0]`←`key_in[255:128]`, `rk[1]`←`key_in[127:0]`.
  - `cur_key`←`key_in`, `rc`←0.
  - Go to EXPAND; `sched_valid` drops on the same edge.
- EXPAND, each cycle:
  - `nk` = `keyExpansion(rc, cur_key)`, one instance, purely combinational.
  - `rk[2+2*rc]`←`nk[255:128]`.
  - If `rc`<6: `rk[3+2*rc]`←`nk[127:0]`, `cur_key`←`nk`, `rc`←`rc`+1.
  - If `rc`==6: discard the lower half (there is no `rk[15]`) and go to DONE.
- DONE with no `key_load`: hold; keys are stable indefinitely.
- `key_load` during EXPAND is ignored and not queued. The requester must hold it until `load_ready`=1.
- Read port: every cycle, `rk_out`←(`rk_idx`≤14) ? `rk[rk_idx]` : 128'h0. It operates in every state.
- Reads in EXPAND return whatever the entry currently holds (possibly stale from the previous key). Consumers must gate on `sched_valid`.
- rc wraps never; the maximum value used is 6. Values 7..15 are unreachable.

## Timing
- Reset (asynchronous assert, synchronous-style release on the next `clk` edge) sets:
  - state=IDLE, `load_ready`=1, `sched_valid`=0
  - `rc`=0, `cur_key`=0, all `rk[*]`=0, `rk_out`=0
- Latency: load accepted at edge E0; expansions occur at edges E1..E7; `sched_valid`=1 and `load_ready`=1 after E7. Total: 7 cycles from acceptance to valid.
- `rk[2k]`, `rk[2k+1]` become readable after edge E(k), for k=1..6; `rk[14]` after E7.
- Read latency: 1 cycle, `rk_idx` at edge N → `rk_out` after edge N.
- Back-to-back: `key_load` held high continuously restarts the schedule at every DONE. `sched_valid` then pulses high for exactly 1 cycle per schedule.
- Reset mid-EXPAND: immediate return to IDLE with all storage cleared. No partial schedule is retained.
- Critical path: `cur_key` → 8 `sbox` lookups (two levels) → XOR chain → `rk`/`cur_key`. This must close in one cycle; no pipelining inside an expansion.

## Test plan
- Reset then idle:
  - `load_ready`=1, `sched_valid`=0, `rk_out`=0 for every `rk_idx` 0..15.
- Load FIPS-197 key `key_in`=000102…1e1f; after 7 cycles `sched_valid`=1, then read:
  - `rk[1]`=101112131415161718191a1b1c1d1e1f
  - `rk[2]`=a573c29fa176c498a97fce93a572c09c
  - `rk[3]`=1651a8cd0244beda1a5da4c10640bade
  - `rk[14]`=24fc79ccbf0979e9371ac23c6d68de36
- Pulse `key_load` with a different key at E3 of an EXPAND:
  - The request is ignored.
  - Final `rk[14]` still matches the first key.
  - `load_ready`=0 throughout E1..E7.
- In DONE, load the all-zero key:
  - `sched_valid` falls the next cycle and rises 7 cycles later.
  - `rk[2]`=62636363626363636263636362636363.
  - `rk[15]` read (idx 15) returns 0.
- Assert `rst_n`=0 mid-EXPAND (after E4), release, reload key 000102…1f:
  - `sched_valid` stays 0 until 7 cycles after the reload.
  - Results match the second scenario.
- Hold `key_load`=1 continuously:
  - `sched_valid` pattern is 1 high / 7 low repeating.
  - `rk` values are identical every schedule.

Source files
------------

// File: rtl/aes256_key_schedule.sv
// AES-256 key schedule: expands a 256-bit cipher key into 15 round keys, one keyExpansion
// step per clock, and serves them through a registered indexed read port.
module aes256_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_load,
    output logic         load_ready,
    output logic         sched_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // One AES-256 expansion step: eight new words from the previous eight.
    function automatic logic [255:0] key_expansion(input logic [3:0] r, input logic [255:0] k);
        logic [31:0] w [8];
        logic [31:0] n [8];
        logic [7:0]  rcon;
        for (int i = 0; i < 8; i++) begin
            w[i] = k[255-32*i -: 32];
        end
        rcon = 8'h01 << r[2:0];
        n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
        n[1] = w[1] ^ n[0];
        n[2] = w[2] ^ n[1];
        n[3] = w[3] ^ n[2];
        n[4] = w[4] ^ sub_word(n[3]);
        n[5] = w[5] ^ n[4];
        n[6] = w[6] ^ n[5];
        n[7] = w[7] ^ n[6];
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

    state_t         state;
    state_t         state_nxt;
    logic [255:0]   cur_key;
    logic [255:0]   nk;
    logic [3:0]     rc;
    logic [127:0]   rk [15];
    logic           load_acc;
    logic           exp_last;
    logic [3:0]     idx_hi;
    logic [3:0]     idx_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_acc  = 1'b0;
        exp_last  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (key_load) begin
                    load_acc  = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (rc == 4'd6) begin
                    exp_last  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_ready  = (state != EXPAND);
    assign sched_valid = (state == DONE);

    assign nk     = key_expansion(rc, cur_key);
    assign idx_hi = {rc[2:0], 1'b0} + 4'd2;
    assign idx_lo = idx_hi + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_key <= '0;
            rc      <= '0;
            rk_out  <= '0;
            for (int i = 0; i < 15; i++) begin
                rk[i] <= '0;
            end
        end else begin
            if (load_acc) begin
                rk[0]   <= key_in[255:128];
                rk[1]   <= key_in[127:0];
                cur_key <= key_in;
                rc      <= '0;
            end else if (state == EXPAND) begin
                rk[idx_hi] <= nk[255:128];
                // The last step has no rk[15]; its lower half is dropped.
                if (!exp_last) begin
                    rk[idx_lo] <= nk[127:0];
                    cur_key    <= nk;
                    rc         <= rc + 4'd1;
                end
            end
            rk_out <= (rk_idx <= 4'd14) ? rk[rk_idx] : '0;
        end
    end

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Directed bench for aes256_key_schedule: reads are issued with an expected
// {load_ready, sched_valid, rk_out} pushed to a queue; a monitor pops and compares.
module tb_aes256_key_schedule;

    logic         clk;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_load;
    logic         load_ready;
    logic         sched_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    localparam logic [255:0] K1   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K2   = 256'hdeadbeef0123456789abcdeffedcba9876543210cafef00d5a5aa5a5c3c33c3c;
    localparam logic [127:0] K1H  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1   = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R2   = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] R3   = 128'h1651a8cd0244beda1a5da4c10640bade;
    localparam logic [127:0] R14  = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] Z2   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z3   = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    logic [129:0] exp_q [$];
    string        name_q [$];
    logic         arm;
    logic         arm_d;
    int           n_vec;
    int           n_miss;

    aes256_key_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_load    (key_load),
        .load_ready  (load_ready),
        .sched_valid (sched_valid),
        .rk_idx      (rk_idx),
        .rk_out      (rk_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d entries still queued", exp_q.size());
        $fatal(1, "watchdog");
    end

    // monitor
    always @(posedge clk) arm_d <= arm;

    always @(negedge clk) begin
        if (arm_d) begin
            logic [129:0] e;
            string        nm;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_read: got rk=%h with no expectation queued", rk_out);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({load_ready, sched_valid, rk_out} !== e) begin
                    n_miss++;
                    $display("FAIL %s: got lr=%0b sv=%0b rk=%h, want lr=%0b sv=%0b rk=%h",
                             nm, load_ready, sched_valid, rk_out, e[129], e[128], e[127:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic lr, input logic sv,
                      input logic [127:0] r, input string nm);
        rk_idx = idx;
        arm    = 1'b1;
        exp_q.push_back({lr, sv, r});
        name_q.push_back(nm);
        step();
        arm = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    // Observations after E1..E7 of a schedule, reading rk[0].
    task automatic expand_watch(input logic [127:0] r0, input string nm);
        for (int i = 1; i <= 7; i++) begin
            rd(4'd0, i == 7, i == 7, r0, nm);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        arm      = 1'b0;
        rst_n    = 1'b0;
        key_in   = '0;
        key_load = 1'b0;
        rk_idx   = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // reset then idle: every index reads 0
        for (int i = 0; i < 16; i++) begin
            rd(i[3:0], 1'b1, 1'b0, 128'h0, "reset_idle");
        end

        // FIPS-197 key
        load_key(K1);
        expand_watch(K1H, "fips_expand");
        rd(4'd1,  1'b1, 1'b1, R1,  "fips_rk1");
        rd(4'd2,  1'b1, 1'b1, R2,  "fips_rk2");
        rd(4'd3,  1'b1, 1'b1, R3,  "fips_rk3");
        rd(4'd14, 1'b1, 1'b1, R14, "fips_rk14");
        rd(4'd0,  1'b1, 1'b1, K1H, "fips_rk0");

        // load request at E3 of an expansion is ignored
        load_key(K1);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) begin
                key_in   = K2;
                key_load = 1'b1;
            end
            rd(4'd0, i == 7, i == 7, K1H, "ignore_expand");
            key_load = 1'b0;
        end
        rd(4'd14, 1'b1, 1'b1, R14, "ignore_rk14");
        rd(4'd1,  1'b1, 1'b1, R1,  "ignore_rk1");

        // all-zero key loaded from DONE
        load_key('0);
        expand_watch(128'h0, "zero_expand");
        rd(4'd2,  1'b1, 1'b1, Z2,     "zero_rk2");
        rd(4'd3,  1'b1, 1'b1, Z3,     "zero_rk3");
        rd(4'd15, 1'b1, 1'b1, 128'h0, "zero_idx15");

        // reset after E4, then reload
        load_key(K1);
        for (int i = 1; i <= 4; i++) begin
            rd(4'd0, 1'b0, 1'b0, K1H, "pre_reset_expand");
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        rd(4'd0, 1'b1, 1'b0, 128'h0, "in_reset");
        rst_n = 1'b1;
        rd(4'd3,  1'b1, 1'b0, 128'h0, "post_reset_rk3");
        rd(4'd14, 1'b1, 1'b0, 128'h0, "post_reset_rk14");
        load_key(K1);
        expand_watch(K1H, "reload_expand");
        rd(4'd2,  1'b1, 1'b1, R2,  "reload_rk2");
        rd(4'd14, 1'b1, 1'b1, R14, "reload_rk14");

        // key_load held high: 1 cycle valid, 7 cycles expanding
        key_in   = K1;
        key_load = 1'b1;
        for (int j = 0; j < 24; j++) begin
            rd(4'd14, (j % 8) == 7, (j % 8) == 7, R14, "b2b_rk14");
        end
        key_load = 1'b0;
        rd(4'd3, 1'b1, 1'b1, R3, "b2b_rk3");

        repeat (3) step();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
